// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
//   Fetch stage and IF/ID pipeline register of the pipelined MIPS core.
//   Holds the PC, drives the instruction-memory address, and registers the
//   fetched word with its PC+4 and a valid flag for the decode stage.
//   Stall requests from the hazard unit freeze the stage. Branch and jump
//   redirects reload the PC and insert a bubble. A redirect overrides a stall.
//
// Ports
//   clk            in   1   rising-edge clock
//   reset          in   1   asynchronous, active-high reset
//   stall          in   1   hold PC and IF/ID contents (load-use hazard)
//   branch_taken   in   1   resolved BEQ/BNE taken, go to branch_target
//   branch_target  in   32  branch destination byte address
//   jump           in   1   J/JAL decoded, go to jump_target
//   jump_target    in   32  jump destination byte address
//   imem_addr      out  32  instruction memory address (equal to pc)
//   imem_data      in   32  instruction word, combinational read of imem_addr
//   pc             out  32  current fetch PC
//   if_id_instr    out  32  registered instruction for decode
//   if_id_pc_plus4 out  32  registered PC+4 of that instruction
//   if_id_valid    out  1   if_id_instr is a real fetched instruction
//   misalign_err   out  1   sticky: a redirect target had addr[1:0] != 0
//   bubble_count   out  16  number of bubbles inserted into IF/ID (wraps)
// ---------------------------------------------------------------------------
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic [15:0] bubble_count
);

  // The IF/ID slot is either empty (bubble) or holds a fetched instruction.
  typedef enum logic {
    ST_BUBBLE   = 1'b0,
    ST_FETCHING = 1'b1
  } fetch_state_e;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_plus4_q, pc_plus4_d;
  logic         misalign_q, misalign_d;
  logic [15:0]  bubble_cnt_q, bubble_cnt_d;

  logic         redirect;
  logic [31:0]  sel_target;
  logic [31:0]  pc_plus4;

  // Branch wins over jump: it belongs to the older instruction in the pipe.
  assign redirect   = branch_taken | jump;
  assign sel_target = branch_taken ? branch_target : jump_target;
  // Unsigned 32-bit add; the carry out is simply dropped so the PC wraps.
  assign pc_plus4   = pc_q + 32'd4;

  always_comb begin
    // NOTE: every _d gets a default (hold) first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_plus4_d   = pc_plus4_q;
    misalign_d   = misalign_q;
    bubble_cnt_d = bubble_cnt_q;

    if (redirect) begin
      pc_d         = {sel_target[31:2], 2'b00};
      instr_d      = NOP_INSTR;
      pc_plus4_d   = 32'd0;
      state_d      = ST_BUBBLE;
      bubble_cnt_d = bubble_cnt_q + 16'd1;
      if (sel_target[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (!stall) begin
      pc_d       = pc_plus4;
      instr_d    = imem_data;
      pc_plus4_d = pc_plus4;
      state_d    = ST_FETCHING;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BUBBLE;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pc_plus4_q   <= 32'd0;
      misalign_q   <= 1'b0;
      bubble_cnt_q <= 16'd0;
    end else begin
      // NOTE: registers are updated with <= so all of them sample the
      // pre-edge values, independent of statement order.
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc_plus4_q   <= pc_plus4_d;
      misalign_q   <= misalign_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc_plus4_q;
  assign if_id_valid    = (state_q == ST_FETCHING);
  assign misalign_err   = misalign_q;
  assign bubble_count   = bubble_cnt_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_stage
//   Directed bench for instruction_fetch_stage. The instruction memory is a
//   pure function of the address, so the expected instruction for any PC can
//   be computed from that PC.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        misalign_err;
  logic [15:0] bubble_count;

  int checks;
  int failures;

  instruction_fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid   (if_id_valid),
    .misalign_err  (misalign_err),
    .bubble_count  (bubble_count)
  );

  // Posedges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, a[31:16] ^ 16'hBEEF};
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the four IF/ID-side outputs against expected values.
  task automatic expect_state(input string tag, input logic [31:0] e_pc,
                              input logic [31:0] e_instr,
                              input logic [31:0] e_pc4, input logic e_valid);
    checks++;
    if (pc !== e_pc) begin
      failures++;
      $display("FAIL %s.pc actual=%h expected=%h", tag, pc, e_pc);
    end
    checks++;
    if (imem_addr !== e_pc) begin
      failures++;
      $display("FAIL %s.imem_addr actual=%h expected=%h", tag, imem_addr, e_pc);
    end
    checks++;
    if (if_id_instr !== e_instr) begin
      failures++;
      $display("FAIL %s.instr actual=%h expected=%h", tag, if_id_instr, e_instr);
    end
    checks++;
    if (if_id_pc_plus4 !== e_pc4) begin
      failures++;
      $display("FAIL %s.pc4 actual=%h expected=%h", tag, if_id_pc_plus4, e_pc4);
    end
    checks++;
    if (if_id_valid !== e_valid) begin
      failures++;
      $display("FAIL %s.valid actual=%b expected=%b", tag, if_id_valid, e_valid);
    end
  endtask

  task automatic expect_flags(input string tag, input logic e_mis,
                              input logic [15:0] e_bub);
    checks++;
    if (misalign_err !== e_mis) begin
      failures++;
      $display("FAIL %s.misalign actual=%b expected=%b", tag, misalign_err, e_mis);
    end
    checks++;
    if (bubble_count !== e_bub) begin
      failures++;
      $display("FAIL %s.bubbles actual=%0d expected=%0d", tag, bubble_count, e_bub);
    end
  endtask

  // Short reset pulse placed between edges.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    // reset has been high since time 0, across the first edge
    #12;
    expect_state("reset", RESET_PC, 32'h0, 32'h0, 1'b0);
    expect_flags("reset", 1'b0, 16'd0);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_free_run();
    expect_state("run0", 32'h0040_0000, 32'h0, 32'h0, 1'b0);
    tick();
    expect_state("run1", 32'h0040_0004, mem_word(32'h0040_0000), 32'h0040_0004, 1'b1);
    tick();
    expect_state("run2", 32'h0040_0008, mem_word(32'h0040_0004), 32'h0040_0008, 1'b1);
    tick();
    expect_state("run3", 32'h0040_000C, mem_word(32'h0040_0008), 32'h0040_000C, 1'b1);
    expect_flags("run3", 1'b0, 16'd0);
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    tick();
    expect_state("pre_stall", 32'h0040_0008, mem_word(32'h0040_0004), 32'h0040_0008, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state($sformatf("stall%0d", i), 32'h0040_0008,
                   mem_word(32'h0040_0004), 32'h0040_0008, 1'b1);
    end
    expect_flags("stall", 1'b0, 16'd0);
    stall = 1'b0;
    tick();
    expect_state("release", 32'h0040_000C, mem_word(32'h0040_0008), 32'h0040_000C, 1'b1);
  endtask

  task automatic test_redirect_over_stall();
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h0040_0040;
    tick();
    branch_taken = 1'b0;
    stall        = 1'b0;
    expect_state("br_stall", 32'h0040_0040, 32'h0, 32'h0, 1'b0);
    expect_flags("br_stall", 1'b0, 16'd1);
  endtask

  task automatic test_back_to_back();
    branch_taken  = 1'b1;
    branch_target = 32'h0040_0100;
    jump          = 1'b1;
    jump_target   = 32'h0040_0200;
    tick();
    expect_state("both", 32'h0040_0100, 32'h0, 32'h0, 1'b0);
    expect_flags("both", 1'b0, 16'd2);
    branch_taken = 1'b0;
    tick();
    expect_state("jump_only", 32'h0040_0200, 32'h0, 32'h0, 1'b0);
    expect_flags("jump_only", 1'b0, 16'd3);
    jump = 1'b0;
    tick();
    expect_state("after_jump", 32'h0040_0204, mem_word(32'h0040_0200), 32'h0040_0204, 1'b1);
  endtask

  task automatic test_misalign();
    jump        = 1'b1;
    jump_target = 32'h0040_0013;
    tick();
    jump = 1'b0;
    expect_state("misalign", 32'h0040_0010, 32'h0, 32'h0, 1'b0);
    expect_flags("misalign", 1'b1, 16'd4);
    tick();
    tick();
    expect_state("mis_hold", 32'h0040_0018, mem_word(32'h0040_0014), 32'h0040_0018, 1'b1);
    expect_flags("mis_hold", 1'b1, 16'd4);
  endtask

  task automatic test_pc_wrap();
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    expect_state("wrap_br", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    tick();
    expect_state("wrap", 32'h0000_0000, mem_word(32'hFFFF_FFFC), 32'h0000_0000, 1'b1);
    expect_flags("wrap", 1'b1, 16'd5);
  endtask

  task automatic test_async_reset();
    tick();
    expect_state("pre_rst", 32'h0000_0004, mem_word(32'h0000_0000), 32'h0000_0004, 1'b1);
    // Assert reset mid-cycle and look before any further clock edge.
    #2;
    reset = 1'b1;
    #1;
    expect_state("async_rst", RESET_PC, 32'h0, 32'h0, 1'b0);
    expect_flags("async_rst", 1'b0, 16'd0);
    reset = 1'b0;
    tick();
    expect_state("post_rst", 32'h0040_0004, mem_word(32'h0040_0000), 32'h0040_0004, 1'b1);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_target   = 32'h0;

    test_reset();
    test_free_run();
    test_stall();
    test_redirect_over_stall();
    test_back_to_back();
    test_misalign();
    test_pc_wrap();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the sequence above ever stops advancing.
  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
